mst_march: RTL and testbench

- Parametrised memory-system tester; successor to the single-pattern 8-bit tester.
- Sits between the test controller and a synchronous-read memory.
- For each of four data patterns, runs a full write pass, then a pipelined read/verify pass.
- Counts attempts and per-pattern failures; tolerates configurable read latency and pausing via enable.

---
 rtl/mst_pkg.sv | 30 +++
 rtl/mst_rd_pipe.sv | 53 +++++
 rtl/mst_march.sv | 204 ++++++++++++++++++++
 tb/tb_mst_march.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mst_pkg.sv
// Shared types and the expected-data function for the mst_march memory tester.
package mst_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] PAT_ZERO  = 2'd0;
  localparam logic [1:0] PAT_ONES  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_ADDR  = 2'd3;

  // Full-width result; callers size-cast down to their data width.
  function automatic logic [MAX_W-1:0] exp_data(input logic [1:0]       pattern,
                                                input logic [MAX_W-1:0] addr);
    case (pattern)
      PAT_ZERO:  exp_data = '0;
      PAT_ONES:  exp_data = '1;
      PAT_CHECK: exp_data = addr[0] ? {(MAX_W/2){2'b10}} : {(MAX_W/2){2'b01}};
      default:   exp_data = addr;
    endcase
  endfunction

endpackage

// File: rtl/mst_rd_pipe.sv
// RD_LAT-deep valid/address/pattern shift register aligning issued reads with
// returning memory data. Always shifts; bubbles are pushed with valid=0.
module mst_rd_pipe #(
  parameter int unsigned AW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [AW-1:0] push_addr,
  input  logic [1:0]    push_pat,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [1:0]    out_pat
);

  logic          valid_q [RD_LAT];
  logic          valid_d [RD_LAT];
  logic [AW-1:0] addr_q  [RD_LAT];
  logic [AW-1:0] addr_d  [RD_LAT];
  logic [1:0]    pat_q   [RD_LAT];
  logic [1:0]    pat_d   [RD_LAT];

  always_comb begin
    valid_d[0] = push_valid;
    addr_d[0]  = push_addr;
    pat_d[0]   = push_pat;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
      pat_d[i]   = pat_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        pat_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];
  assign out_pat   = pat_q[RD_LAT-1];

endmodule

// File: rtl/mst_march.sv
// Four-pattern write/read-verify memory tester with per-pattern fail counters.
// Optional first-fail capture ports are built when MST_FIRST_FAIL_CAPTURE_EN is defined.
module mst_march
  import mst_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic [DW-1:0]       rdd,
  output logic [AW-1:0]       rda,
  output logic                we,
  output logic [AW-1:0]       wra,
  output logic [DW-1:0]       wrd,
  output logic [1:0]          pattern,
  output logic [AW+2:0]       attempts,
  output logic [4*(AW+1)-1:0] fails,
  output logic                busy,
  output logic                done
`ifdef MST_FIRST_FAIL_CAPTURE_EN
  ,
  output logic                ff_valid,
  output logic [AW-1:0]       ff_addr,
  output logic [1:0]          ff_pattern,
  output logic [DW-1:0]       ff_exp,
  output logic [DW-1:0]       ff_act
`endif
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    pat_q, pat_d;
  logic [2:0]    drain_q, drain_d;
  logic [AW+2:0] att_q, att_d;
  logic [AW:0]   fail_q [4];
  logic [AW:0]   fail_d [4];

  logic          push_valid, start_ok, miss;
  logic          pv;
  logic [AW-1:0] pa;
  logic [1:0]    pp;
  logic [DW-1:0] cmp_exp;

  assign push_valid = (state_q == READ) && enable;

  mst_rd_pipe #(.AW(AW), .RD_LAT(RD_LAT)) u_rd_pipe (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_addr  (addr_q),
    .push_pat   (pat_q),
    .out_valid  (pv),
    .out_addr   (pa),
    .out_pat    (pp)
  );

  // Compare against the pattern that travelled with the read, not the live one.
  assign cmp_exp = DW'(exp_data(pp, MAX_W'(pa)));
  assign miss    = pv && (rdd != cmp_exp);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pat_d    = pat_q;
    drain_d  = drain_q;
    att_d    = att_q;
    fail_d   = fail_q;
    start_ok = 1'b0;

    if (pv) att_d = att_q + 1'b1;
    if (miss && (fail_q[pp] != '1)) fail_d[pp] = fail_q[pp] + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = WRITE;
          addr_d   = '0;
          pat_d    = PAT_ZERO;
          drain_d  = '0;
          att_d    = '0;
          for (int unsigned p = 0; p < 4; p++) fail_d[p] = '0;
        end
      end
      WRITE: begin
        if (enable) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == '1) state_d = READ;
        end
      end
      READ: begin
        if (enable) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == '1) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 3'(RD_LAT - 1)) begin
          drain_d = '0;
          addr_d  = '0;
          if (pat_q == PAT_ADDR) begin
            state_d = DONE;
          end else begin
            pat_d   = pat_q + 2'd1;
            state_d = WRITE;
          end
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pat_q   <= '0;
      drain_q <= '0;
      att_q   <= '0;
      for (int unsigned p = 0; p < 4; p++) fail_q[p] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      drain_q <= drain_d;
      att_q   <= att_d;
      fail_q  <= fail_d;
    end
  end

  assign we       = (state_q == WRITE) && enable;
  assign wra      = addr_q;
  assign wrd      = DW'(exp_data(pat_q, MAX_W'(addr_q)));
  assign rda      = addr_q;
  assign pattern  = pat_q;
  assign attempts = att_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);

  always_comb begin
    fails = '0;
    for (int unsigned p = 0; p < 4; p++) fails[p*(AW+1) +: AW+1] = fail_q[p];
  end

`ifdef MST_FIRST_FAIL_CAPTURE_EN
  logic          ffv_q, ffv_d;
  logic [AW-1:0] ffa_q, ffa_d;
  logic [1:0]    ffp_q, ffp_d;
  logic [DW-1:0] ffe_q, ffe_d, ffx_q, ffx_d;

  always_comb begin
    ffv_d = ffv_q;
    ffa_d = ffa_q;
    ffp_d = ffp_q;
    ffe_d = ffe_q;
    ffx_d = ffx_q;
    if (start_ok) begin
      ffv_d = 1'b0;
      ffa_d = '0;
      ffp_d = '0;
      ffe_d = '0;
      ffx_d = '0;
    end else if (miss && !ffv_q) begin
      ffv_d = 1'b1;
      ffa_d = pa;
      ffp_d = pp;
      ffe_d = cmp_exp;
      ffx_d = rdd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ffv_q <= 1'b0;
      ffa_q <= '0;
      ffp_q <= '0;
      ffe_q <= '0;
      ffx_q <= '0;
    end else begin
      ffv_q <= ffv_d;
      ffa_q <= ffa_d;
      ffp_q <= ffp_d;
      ffe_q <= ffe_d;
      ffx_q <= ffx_d;
    end
  end

  assign ff_valid   = ffv_q;
  assign ff_addr    = ffa_q;
  assign ff_pattern = ffp_q;
  assign ff_exp     = ffe_q;
  assign ff_act     = ffx_q;
`endif

endmodule

// File: tb/tb_mst_march.sv
// Directed bench for mst_march: ideal, stuck-bit, 3-cycle-latency and aliased memories.
module tb_mst_march;
  import mst_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  // DUT A: DW=8, AW=4, RD_LAT=1, ideal or bit0-stuck-at-1 memory
  logic       start_a, en_a, stuck;
  logic [7:0] rdd_a, wrd_a;
  logic [3:0] rda_a, wra_a;
  logic       we_a, busy_a, done_a;
  logic [1:0] pattern_a;
  logic [6:0] attempts_a;
  logic [19:0] fails_a;
`ifdef MST_FIRST_FAIL_CAPTURE_EN
  logic       ffv_a;
  logic [3:0] ffa_a;
  logic [1:0] ffp_a;
  logic [7:0] ffe_a, ffx_a;
`endif

  mst_march #(.DW(8), .AW(4), .RD_LAT(1)) dut_a (
    .clock(clk), .reset(rst), .enable(en_a), .start(start_a), .rdd(rdd_a),
    .rda(rda_a), .we(we_a), .wra(wra_a), .wrd(wrd_a), .pattern(pattern_a),
    .attempts(attempts_a), .fails(fails_a), .busy(busy_a), .done(done_a)
`ifdef MST_FIRST_FAIL_CAPTURE_EN
    , .ff_valid(ffv_a), .ff_addr(ffa_a), .ff_pattern(ffp_a), .ff_exp(ffe_a), .ff_act(ffx_a)
`endif
  );

  logic [7:0] mem_a [16];
  always @(posedge clk) begin
    if (we_a) mem_a[wra_a] <= wrd_a;
    rdd_a <= mem_a[rda_a] | {7'd0, stuck};
  end

  // DUT B: RD_LAT=3 with a matching three-stage memory
  logic       start_b, en_b;
  logic [7:0] rdd_b, wrd_b, b_r1, b_r2;
  logic [3:0] rda_b, wra_b;
  logic       we_b, busy_b, done_b;
  logic [1:0] pattern_b;
  logic [6:0] attempts_b;
  logic [19:0] fails_b;
`ifdef MST_FIRST_FAIL_CAPTURE_EN
  logic       ffv_b;
  logic [3:0] ffa_b;
  logic [1:0] ffp_b;
  logic [7:0] ffe_b, ffx_b;
`endif

  mst_march #(.DW(8), .AW(4), .RD_LAT(3)) dut_b (
    .clock(clk), .reset(rst), .enable(en_b), .start(start_b), .rdd(rdd_b),
    .rda(rda_b), .we(we_b), .wra(wra_b), .wrd(wrd_b), .pattern(pattern_b),
    .attempts(attempts_b), .fails(fails_b), .busy(busy_b), .done(done_b)
`ifdef MST_FIRST_FAIL_CAPTURE_EN
    , .ff_valid(ffv_b), .ff_addr(ffa_b), .ff_pattern(ffp_b), .ff_exp(ffe_b), .ff_act(ffx_b)
`endif
  );

  logic [7:0] mem_b [16];
  always @(posedge clk) begin
    if (we_b) mem_b[wra_b] <= wrd_b;
    b_r1  <= mem_b[rda_b];
    b_r2  <= b_r1;
    rdd_b <= b_r2;
  end

  // DUT C: AW=2, address 3 aliased onto address 1
  logic       start_c, en_c;
  logic [7:0] rdd_c, wrd_c;
  logic [1:0] rda_c, wra_c;
  logic       we_c, busy_c, done_c;
  logic [1:0] pattern_c;
  logic [4:0] attempts_c;
  logic [11:0] fails_c;
`ifdef MST_FIRST_FAIL_CAPTURE_EN
  logic       ffv_c;
  logic [1:0] ffa_c;
  logic [1:0] ffp_c;
  logic [7:0] ffe_c, ffx_c;
`endif

  mst_march #(.DW(8), .AW(2), .RD_LAT(1)) dut_c (
    .clock(clk), .reset(rst), .enable(en_c), .start(start_c), .rdd(rdd_c),
    .rda(rda_c), .we(we_c), .wra(wra_c), .wrd(wrd_c), .pattern(pattern_c),
    .attempts(attempts_c), .fails(fails_c), .busy(busy_c), .done(done_c)
`ifdef MST_FIRST_FAIL_CAPTURE_EN
    , .ff_valid(ffv_c), .ff_addr(ffa_c), .ff_pattern(ffp_c), .ff_exp(ffe_c), .ff_act(ffx_c)
`endif
  );

  function automatic logic [1:0] alias_idx(input logic [1:0] a);
    return (a == 2'd3) ? 2'd1 : a;
  endfunction

  logic [7:0] mem_c [4];
  always @(posedge clk) begin
    if (we_c) mem_c[alias_idx(wra_c)] <= wrd_c;
    rdd_c <= mem_c[alias_idx(rda_c)];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on A, follow the run to done, checking pattern-2 write data on the way.
  task automatic run_a(input bit poke, output int cyc);
    int k;
    k = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_clr_attempts", attempts_a, 0);
    chk("start_clr_fails", fails_a, 0);
    chk("start_busy", busy_a, 1);
    chk("start_done_low", done_a, 0);
    cyc = 0;
    while (!done_a && cyc < 2000) begin
      if (we_a && pattern_a == 2'd2) begin
        chk("p2_wra", wra_a, k);
        chk("p2_wrd", wrd_a, (k % 2 != 0) ? 8'hAA : 8'h55);
        k++;
      end
      start_a = poke && (cyc == 40);
      tick();
      cyc++;
    end
    start_a = 1'b0;
    chk("p2_write_count", k, 16);
    chk("run_done", done_a, 1);
  endtask

  initial begin
    int cyc, n, viol;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    stuck = 1'b0;
    repeat (3) tick();

    chk("rst_we", we_a, 0);
    chk("rst_wra", wra_a, 0);
    chk("rst_wrd", wrd_a, 0);
    chk("rst_rda", rda_a, 0);
    chk("rst_pattern", pattern_a, 0);
    chk("rst_attempts", attempts_a, 0);
    chk("rst_fails", fails_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
`ifdef MST_FIRST_FAIL_CAPTURE_EN
    chk("rst_ff_valid", ffv_a, 0);
`endif
    rst = 1'b0;
    tick();

    // Ideal run with a start pulse injected mid-run; it must be ignored.
    run_a(1'b1, cyc);
    chk("run1_cycles", cyc, 132);
    chk("run1_attempts", attempts_a, 64);
    chk("run1_fails", fails_a, 0);
    chk("run1_busy", busy_a, 0);

    // Restart from DONE must reproduce the same run.
    run_a(1'b0, cyc);
    chk("run2_cycles", cyc, 132);
    chk("run2_attempts", attempts_a, 64);
    chk("run2_fails", fails_a, 0);

    // Bit0 stuck at 1: p0 all 16, p1 none, p2 odd addrs, p3 even addrs.
    stuck = 1'b1;
    run_a(1'b0, cyc);
    chk("stuck_cycles", cyc, 132);
    chk("stuck_attempts", attempts_a, 64);
    chk("stuck_fails", fails_a, {5'd8, 5'd8, 5'd0, 5'd16});
`ifdef MST_FIRST_FAIL_CAPTURE_EN
    chk("ff_valid", ffv_a, 1);
    chk("ff_addr", ffa_a, 0);
    chk("ff_pattern", ffp_a, 0);
    chk("ff_exp", ffe_a, 8'h00);
    chk("ff_act", ffx_a, 8'h01);
`endif
    stuck = 1'b0;

    // Reset in the middle of the pattern-1 write pass.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!(pattern_a == 2'd1 && we_a) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_p1_write", pattern_a, 1);
    repeat (3) tick();
    chk("p1_mid_write_we", we_a, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_we", we_a, 0);
    chk("mid_rst_wra", wra_a, 0);
    chk("mid_rst_wrd", wrd_a, 0);
    chk("mid_rst_rda", rda_a, 0);
    chk("mid_rst_pattern", pattern_a, 0);
    chk("mid_rst_attempts", attempts_a, 0);
    chk("mid_rst_fails", fails_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_state", dut_a.state_q, IDLE);
`ifdef MST_FIRST_FAIL_CAPTURE_EN
    chk("mid_rst_ff_valid", ffv_a, 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_holds_we", we_a, 0);
    run_a(1'b0, cyc);
    chk("fresh_cycles", cyc, 132);
    chk("fresh_attempts", attempts_a, 64);
    chk("fresh_fails", fails_a, 0);

    // RD_LAT=3 with enable toggling every cycle.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    viol = 0;
    while (!done_b && n < 4000) begin
      if (we_b && (dut_b.state_q == READ || dut_b.state_q == DRAIN)) viol++;
      en_b = ~en_b;
      tick();
      n++;
    end
    en_b = 1'b1;
    chk("b_done", done_b, 1);
    chk("b_attempts", attempts_b, 64);
    chk("b_fails", fails_b, 0);
    chk("b_we_in_read", viol, 0);

    // AW=2 aliasing: in pattern 3 only address 1 reads back the wrong value (3).
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    n = 0;
    while (!done_c && n < 500) begin
      tick();
      n++;
    end
    chk("c_cycles", n, 36);
    chk("c_attempts", attempts_c, 16);
    chk("c_fails", fails_c, {3'd1, 3'd0, 3'd0, 3'd0});

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
